// File: rtl/cc1200_pkg.sv
// Shared types and helpers for the CC1200 SPI arbiter.
package cc1200_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    DONE,
    GAP
  } state_t;

  localparam logic [7:0]  STRM_HDR_DEF = 8'h7F;
  localparam logic        OWNER_CPU    = 1'b0;
  localparam logic        OWNER_STRM   = 1'b1;
  localparam int unsigned QUOTA_W      = 8;
  localparam int unsigned CNT_W        = 16;

  // Engine byte count: 0 means 1, anything above 4 means 4.
  function automatic logic [3:0] clamp_nbytes(input logic [3:0] n);
    if (n == 4'd0) return 4'd1;
    if (n > 4'd4)  return 4'd4;
    return n;
  endfunction

endpackage

// File: rtl/cc1200_arb_pick.sv
// Combinational cpu/stream priority pick with stream quota.
module cc1200_arb_pick
  import cc1200_pkg::*;
#(
  parameter int unsigned STRM_QUOTA = 8
) (
  input  logic               cpu_req,
  input  logic               strm_en,
  input  logic               last_owner,
  input  logic [QUOTA_W-1:0] quota,
  output logic               grant_vld_c,
  output logic               grant_owner_c
);

  // Stream wins only when cpu is absent or stream still has quota left.
  always_comb begin
    grant_vld_c   = cpu_req | strm_en;
    grant_owner_c = OWNER_CPU;
    if (strm_en && (!cpu_req ||
        (last_owner == OWNER_STRM && quota < QUOTA_W'(STRM_QUOTA))))
      grant_owner_c = OWNER_STRM;
  end

endmodule

// File: rtl/cc1200_spi_arbiter.sv
// Shares one CC1200 SPI engine between the APB cpu path and the sample stream.
module cc1200_spi_arbiter
  import cc1200_pkg::*;
#(
  parameter logic [7:0]  STRM_HDR     = STRM_HDR_DEF,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned BUSY_TIMEOUT = 64,
  parameter int unsigned STRM_QUOTA   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_nbytes,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        strm_en,
  input  logic [11:0] strm_data,
  output logic        strm_next,
  input  logic        abort,
  output logic        spi_start,
  output logic [31:0] spi_dout,
  output logic [3:0]  spi_nbytes,
  input  logic        spi_busy,
  input  logic [31:0] spi_din,
  output logic        busy,
  output logic        owner,
  output logic [15:0] strm_cnt,
  output logic        timeout_flag
);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [QUOTA_W-1:0] quota, quota_d;
  logic               abt_pend, abt_d;
  logic               tmo_pend, tmo_d;
  logic               grant_vld_c, grant_owner_c;

  logic        cpu_ack_d, cpu_err_d, strm_next_d, spi_start_d, busy_d, owner_d, timeout_flag_d;
  logic [31:0] cpu_rdata_d, spi_dout_d;
  logic [3:0]  spi_nbytes_d;
  logic [15:0] strm_cnt_d;

  cc1200_arb_pick #(.STRM_QUOTA(STRM_QUOTA)) u_pick (
    .cpu_req      (cpu_req),
    .strm_en      (strm_en),
    .last_owner   (owner),
    .quota        (quota),
    .grant_vld_c  (grant_vld_c),
    .grant_owner_c(grant_owner_c)
  );

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    quota_d        = quota;
    abt_d          = abt_pend;
    tmo_d          = tmo_pend;
    owner_d        = owner;
    timeout_flag_d = timeout_flag;
    cpu_ack_d      = 1'b0;
    cpu_err_d      = 1'b0;
    strm_next_d    = 1'b0;
    spi_start_d    = 1'b0;
    cpu_rdata_d    = cpu_rdata;
    spi_dout_d     = spi_dout;
    spi_nbytes_d   = spi_nbytes;
    strm_cnt_d     = strm_cnt;

    case (state)
      IDLE: begin
        if (grant_vld_c) begin
          state_d     = ISSUE;
          owner_d     = grant_owner_c;
          spi_start_d = 1'b1;
          abt_d       = 1'b0;
          tmo_d       = 1'b0;
          if (grant_owner_c == OWNER_STRM) begin
            quota_d      = (quota < QUOTA_W'(STRM_QUOTA)) ? quota + QUOTA_W'(1) : quota;
            spi_dout_d   = {STRM_HDR, 4'h0, strm_data, 8'h00};
            spi_nbytes_d = 4'd3;
            strm_next_d  = 1'b1;
          end else begin
            quota_d      = '0;
            spi_dout_d   = cpu_wdata;
            spi_nbytes_d = clamp_nbytes(cpu_nbytes);
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT)) begin
          state_d        = DONE;
          tmo_d          = 1'b1;
          timeout_flag_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!spi_busy) state_d = DONE;
      end
      DONE: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt >= CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else                               cnt_d   = cnt + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // An abort cannot cut the engine; it only marks the outcome.
    if (abort && (state == ISSUE || state == WAIT_BUSY || state == WAIT_DONE))
      abt_d = 1'b1;

    // Completion outputs are registered so they appear during DONE.
    if (state != DONE && state_d == DONE) begin
      if (owner == OWNER_CPU) begin
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = spi_din;
        cpu_err_d   = abt_d | tmo_d;
      end else begin
        if (!tmo_d) strm_cnt_d = strm_cnt + 16'd1;
        if (abt_d)  quota_d    = '0;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      quota        <= '0;
      abt_pend     <= 1'b0;
      tmo_pend     <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      cpu_err      <= 1'b0;
      strm_next    <= 1'b0;
      spi_start    <= 1'b0;
      spi_dout     <= '0;
      spi_nbytes   <= '0;
      busy         <= 1'b0;
      owner        <= OWNER_CPU;
      strm_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      quota        <= quota_d;
      abt_pend     <= abt_d;
      tmo_pend     <= tmo_d;
      cpu_ack      <= cpu_ack_d;
      cpu_rdata    <= cpu_rdata_d;
      cpu_err      <= cpu_err_d;
      strm_next    <= strm_next_d;
      spi_start    <= spi_start_d;
      spi_dout     <= spi_dout_d;
      spi_nbytes   <= spi_nbytes_d;
      busy         <= busy_d;
      owner        <= owner_d;
      strm_cnt     <= strm_cnt_d;
      timeout_flag <= timeout_flag_d;
    end
  end

endmodule

// File: tb/tb_cc1200_spi_arbiter.sv
// Directed bench for cc1200_spi_arbiter with a simple engine and sample source model.
module tb_cc1200_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_nbytes;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        strm_en;
  logic [11:0] strm_data;
  logic        strm_next;
  logic        abort;
  logic        spi_start;
  logic [31:0] spi_dout;
  logic [3:0]  spi_nbytes;
  logic        spi_busy;
  logic [31:0] spi_din;
  logic        busy;
  logic        owner;
  logic [15:0] strm_cnt;
  logic        timeout_flag;

  always #5 clk = ~clk;

  cc1200_spi_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_wdata   (cpu_wdata),
    .cpu_nbytes  (cpu_nbytes),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .cpu_err     (cpu_err),
    .strm_en     (strm_en),
    .strm_data   (strm_data),
    .strm_next   (strm_next),
    .abort       (abort),
    .spi_start   (spi_start),
    .spi_dout    (spi_dout),
    .spi_nbytes  (spi_nbytes),
    .spi_busy    (spi_busy),
    .spi_din     (spi_din),
    .busy        (busy),
    .owner       (owner),
    .strm_cnt    (strm_cnt),
    .timeout_flag(timeout_flag)
  );

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: busy for eng_len cycles starting the edge after spi_start.
  int unsigned eng_len = 20;
  bit          eng_never = 1'b0;
  int unsigned eng_cnt;
  always @(posedge clk) begin
    if (rst) begin
      spi_busy <= 1'b0;
      eng_cnt  <= 0;
    end else if (spi_start && !eng_never) begin
      spi_busy <= 1'b1;
      eng_cnt  <= eng_len;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) spi_busy <= 1'b0;
    end
  end

  // Sample source: 12'h07F, 12'h07E, ... advancing on strm_next.
  logic [11:0] src_idx;
  always @(posedge clk) begin
    if (rst)            src_idx <= '0;
    else if (strm_next) src_idx <= src_idx + 12'd1;
  end
  assign strm_data = 12'h07F - src_idx;

  // Transaction log.
  logic [31:0] st_dout [32];
  logic [3:0]  st_nb   [32];
  logic        st_own  [32];
  int unsigned st_cyc  [32];
  int unsigned f_cyc   [32];
  int unsigned n_start, n_next, n_ack, n_fall;
  logic        busy_q = 1'b0;

  function automatic logic [4:0] ix(input int unsigned x);
    return x[4:0];
  endfunction

  always @(negedge clk) begin
    if (spi_start) begin
      st_dout[ix(n_start)] <= spi_dout;
      st_nb[ix(n_start)]   <= spi_nbytes;
      st_own[ix(n_start)]  <= owner;
      st_cyc[ix(n_start)]  <= cyc;
      n_start <= n_start + 1;
    end
    if (strm_next) n_next <= n_next + 1;
    if (cpu_ack)   n_ack  <= n_ack + 1;
    if (busy_q && !spi_busy) begin
      f_cyc[ix(n_fall)] <= cyc;
      n_fall <= n_fall + 1;
    end
    busy_q <= spi_busy;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; strm_en = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input string tag, output logic [31:0] rd, output logic er,
                          output int unsigned ac);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cpu_ack) begin seen = 1'b1; break; end
    end
    rd = cpu_rdata; er = cpu_err; ac = cyc;
    chk({tag, "_ack_seen"}, 96'(seen), 96'd1);
  endtask

  task automatic wait_next(input string tag, input int n);
    int k = 0;
    for (int i = 0; i < 3000 && k < n; i++) begin
      @(negedge clk);
      if (strm_next) k++;
    end
    chk({tag, "_strm_next"}, 96'(k), 96'(n));
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && !spi_busy) break;
    end
    chk({tag, "_idle"}, 96'(busy), 96'd0);
  endtask

  int unsigned sb, fb, nb, na, ac, r, lead;
  logic [31:0] rd;
  logic        er;
  logic [11:0] d;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_wdata = '0; cpu_nbytes = '0;
    strm_en = 1'b0; abort = 1'b0; spi_din = 32'h12345679;
    repeat (3) @(negedge clk);
    chk("reset_outs", 96'({cpu_ack, cpu_rdata, cpu_err, strm_next, spi_start, spi_dout,
                           spi_nbytes, busy, owner, strm_cnt, timeout_flag}), 96'd0);
    rst = 1'b0;

    // 1: single cpu byte
    eng_len = 20; sb = n_start; fb = n_fall;
    @(negedge clk);
    cpu_wdata = 32'h00B3456D; cpu_nbytes = 4'd1; cpu_req = 1'b1; r = cyc;
    wait_ack("t1", rd, er, ac);
    cpu_req = 1'b0;
    chk("t1_rdata", 96'(rd), 96'h12345679);
    chk("t1_err", 96'(er), 96'd0);
    chk("t1_ack_after_fall", 96'(ac - f_cyc[ix(fb)]), 96'd1);
    settle("t1");
    chk("t1_nstart", 96'(n_start - sb), 96'd1);
    chk("t1_start_lat", 96'(st_cyc[ix(sb)] - r), 96'd1);
    chk("t1_nbytes", 96'(st_nb[ix(sb)]), 96'd1);
    chk("t1_dout", 96'(st_dout[ix(sb)]), 96'h00B3456D);

    // 2: ten stream samples
    do_reset();
    eng_len = 3; sb = n_start; fb = n_fall; nb = n_next;
    strm_en = 1'b1;
    wait_next("t2", 10);
    strm_en = 1'b0;
    settle("t2");
    chk("t2_nstart", 96'(n_start - sb), 96'd10);
    chk("t2_nnext", 96'(n_next - nb), 96'd10);
    chk("t2_strm_cnt", 96'(strm_cnt), 96'd10);
    chk("t2_owner", 96'(owner), 96'd1);
    chk("t2_first_dout", 96'(st_dout[ix(sb)]), 96'h7F007F00);
    for (int i = 1; i < 10; i++) begin
      d = 12'h07F - 12'(i);
      chk("t2_dout", 96'(st_dout[ix(sb + i)]), 96'({8'h7F, 4'h0, d, 8'h00}));
    end
    chk("t2_nbytes", 96'(st_nb[ix(sb + 9)]), 96'd3);
    chk("t2_gap", 96'(st_cyc[ix(sb + 1)] - f_cyc[ix(fb)]), 96'd7);

    // 3: stream quota against a pending cpu request
    do_reset();
    sb = n_start;
    strm_en = 1'b1;
    wait_next("t3a", 2);
    cpu_wdata = 32'hA5C30000; cpu_nbytes = 4'd2; cpu_req = 1'b1;
    wait_ack("t3", rd, er, ac);
    cpu_req = 1'b0;
    chk("t3_err", 96'(er), 96'd0);
    wait_next("t3b", 2);
    strm_en = 1'b0;
    settle("t3");
    lead = 0;
    for (int i = 0; i < 11; i++) if (lead == i && st_own[ix(sb + i)]) lead++;
    chk("t3_stream_run", 96'(lead), 96'd8);
    chk("t3_cpu_owner", 96'(st_own[ix(sb + 8)]), 96'd0);
    chk("t3_cpu_dout", 96'(st_dout[ix(sb + 8)]), 96'hA5C30000);
    chk("t3_cpu_nbytes", 96'(st_nb[ix(sb + 8)]), 96'd2);
    chk("t3_resume", 96'(st_own[ix(sb + 9)]), 96'd1);
    chk("t3_nstart", 96'(n_start - sb), 96'd11);

    // 4: engine never goes busy
    do_reset();
    eng_never = 1'b1; sb = n_start;
    cpu_wdata = 32'hDEADBEEF; cpu_nbytes = 4'd4; cpu_req = 1'b1;
    wait_ack("t4", rd, er, ac);
    cpu_req = 1'b0;
    chk("t4_ack_lat", 96'(ac - st_cyc[ix(sb)]), 96'd66);
    chk("t4_err", 96'(er), 96'd1);
    chk("t4_tflag", 96'(timeout_flag), 96'd1);
    settle("t4a");
    eng_never = 1'b0; eng_len = 5;
    cpu_nbytes = 4'd0; cpu_req = 1'b1;
    wait_ack("t4b", rd, er, ac);
    cpu_req = 1'b0;
    chk("t4b_err", 96'(er), 96'd0);
    chk("t4b_tflag_sticky", 96'(timeout_flag), 96'd1);
    settle("t4b");
    chk("t4b_nbytes_zero", 96'(st_nb[ix(sb + 1)]), 96'd1);
    do_reset();
    chk("t4_tflag_rst", 96'(timeout_flag), 96'd0);

    // 5: abort while the engine is busy
    eng_len = 20; sb = n_start; fb = n_fall;
    cpu_wdata = 32'h0F0F1234; cpu_nbytes = 4'd9; cpu_req = 1'b1;
    for (int i = 0; i < 100 && !spi_busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_ack("t5", rd, er, ac);
    cpu_req = 1'b0;
    chk("t5_err", 96'(er), 96'd1);
    chk("t5_ack_after_fall", 96'(ac - f_cyc[ix(fb)]), 96'd1);
    settle("t5a");
    chk("t5_nbytes_clamp", 96'(st_nb[ix(sb)]), 96'd4);
    spi_din = 32'hCAFEF00D; cpu_nbytes = 4'd2; cpu_req = 1'b1;
    wait_ack("t5b", rd, er, ac);
    cpu_req = 1'b0;
    chk("t5b_err", 96'(er), 96'd0);
    chk("t5b_rdata", 96'(rd), 96'hCAFEF00D);
    settle("t5b");

    // 6: counter wrap, then reset in the middle of a transfer
    do_reset();
    eng_len = 3;
    force dut.strm_cnt = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.strm_cnt;
    strm_en = 1'b1;
    wait_next("t6", 1);
    strm_en = 1'b0;
    settle("t6a");
    chk("t6_wrap", 96'(strm_cnt), 96'd0);
    eng_len = 20; na = n_ack;
    cpu_wdata = 32'h11223344; cpu_nbytes = 4'd4; cpu_req = 1'b1;
    for (int i = 0; i < 100 && !spi_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("t6_rst_outs", 96'({cpu_ack, cpu_rdata, cpu_err, strm_next, spi_start, spi_dout,
                            spi_nbytes, busy, owner, strm_cnt, timeout_flag}), 96'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_no_ack", 96'(n_ack - na), 96'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cc1200_spi_arbiter.md
Name: cc1200_spi_arbiter

Overview:
Sequencer and arbiter that shares the single CC1200 SPI engine between two requesters: the APB register path (single CPU transactions) and the streaming sample path (12-bit samples from the test memory, GetDataEn/GetData/Next_data style). It owns the engine's Start/Busy handshake, frames each stream sample as a 3-byte burst write, enforces an inter-transaction CS gap and detects a hung engine. It sits between the APB register bank / sample source and the SPI engine, all in the `clk` domain.

Parameters:
STRM_HDR, 8'h7F, command byte prefixed to every stream sample (burst TX FIFO write)
GAP_CYCLES, 4, idle clk cycles enforced between engine transactions (min 1)
BUSY_TIMEOUT, 64, clk cycles allowed from spi_start to spi_busy rising
STRM_QUOTA, 8, max consecutive stream grants while cpu_req is pending

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_req  in  1  level; held until cpu_ack
cpu_wdata  in  32  bytes to send, MSB-first
cpu_nbytes  in  4  byte count 1..4; 0 treated as 1, >4 clamped to 4
cpu_ack  out  1  one-cycle pulse, transaction finished
cpu_rdata  out  32  spi_din captured at completion, valid with cpu_ack
cpu_err  out  1  valid with cpu_ack; 1 = timeout or abort
strm_en  in  1  level; sample source has data
strm_data  in  12  current sample
strm_next  out  1  one-cycle pulse; sample consumed, source advances
abort  in  1  pulse; cancel current/pending work
spi_start  out  1  one-cycle start pulse to engine
spi_dout  out  32  engine data, left-justified
spi_nbytes  out  4  engine byte count
spi_busy  in  1  engine busy
spi_din  in  32  engine receive data
busy  out  1  high in any state except IDLE
owner  out  1  0 = cpu, 1 = stream; last grant
strm_cnt  out  16  samples sent, wraps at 16'hFFFF -> 0
timeout_flag  out  1  sticky; cleared only by rst

Behaviour:
- Reset: all outputs 0; state IDLE; quota counter 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE, GAP.
- IDLE: arbitrate combinationally and register the grant. Priority: cpu_req beats strm_en, unless the last grant was stream and the quota counter < STRM_QUOTA. A cpu grant clears the quota counter; a stream grant increments it, saturating. Neither pending -> stay in IDLE.
- ISSUE (1 cycle): spi_start=1 and spi_dout/spi_nbytes loaded.
  - cpu: spi_dout = cpu_wdata, spi_nbytes = clamped count.
  - stream: spi_dout = {STRM_HDR, 4'h0, strm_data[11:8], strm_data[7:0], 8'h00}, spi_nbytes = 3.
  - strm_data is latched here; strm_next pulses in this same cycle.
  - spi_dout and spi_nbytes hold until DONE.
- WAIT_BUSY: go to WAIT_DONE on spi_busy=1. If the counter reaches BUSY_TIMEOUT first: set timeout_flag and go to DONE with err=1.
- WAIT_DONE: go to DONE on spi_busy=0. No timeout here; the engine bounds the transfer length.
- DONE (1 cycle):
  - cpu owner: cpu_ack=1, cpu_rdata = spi_din, cpu_err.
  - stream owner: strm_cnt increments, unless the timeout path was taken.
- GAP: wait GAP_CYCLES, then IDLE.
- Latency: a cpu request from IDLE gives spi_start 1 cycle after cpu_req is sampled. cpu_ack comes 1 cycle after spi_busy falls.
- Abort:
  - In IDLE or GAP: ignored.
  - In ISSUE/WAIT_BUSY/WAIT_DONE: the transfer in flight completes (the engine cannot be cut mid-byte), but DONE reports cpu_err=1 for a cpu owner.
  - Stream: the sample counts as sent; the quota counter is cleared.
- cpu_req dropped before ack is a protocol violation; behaviour is undefined and assertion-checked in the bench.
- strm_en dropping after grant has no effect; the sample is already latched.
- rst mid-transfer: immediate return to IDLE. The engine is reset by the same rst.

Decomposition:
- Shared package cc1200_pkg:
  - state enum
  - STRM_HDR default
  - byte-count clamp function
  - owner encoding constants
- One sub-module, cc1200_arb_pick: pure priority/quota arbiter, inputs cpu_req, strm_en, last owner, quota counter; output grant.
- Everything else stays in the top FSM.

Test Plan:
1. cpu_req with cpu_wdata=32'h00B3456D, nbytes=1; engine model busy for 20 cycles, spi_din=32'h12345679 -> one spi_start; spi_nbytes=1; cpu_ack 1 cycle after busy falls; cpu_rdata=32'h12345679, cpu_err=0.
2. strm_en held, strm_data stepping 12'h07F,12'h07E,... for 10 samples -> each transaction spi_dout = {8'h7F,8'h00,8'h7F,8'h00} for the first sample; spi_nbytes=3; strm_next once per sample; strm_cnt=10; at least GAP_CYCLES between busy fall and the next spi_start.
3. strm_en held, cpu_req raised after the 2nd stream grant -> exactly STRM_QUOTA=8 consecutive stream grants, then the cpu grant, then stream resumes.
4. Engine model never asserts busy -> cpu_ack at BUSY_TIMEOUT+2 cycles after start with cpu_err=1; timeout_flag=1 and sticky until rst.
5. abort during WAIT_DONE of a cpu transfer -> transfer completes; cpu_ack with cpu_err=1; next request serviced normally.
6. strm_cnt preloaded near the top via 65535 samples (or forced to 16'hFFFF) -> next sample gives 16'h0000; rst asserted during WAIT_DONE -> all outputs 0 on the next cycle, no cpu_ack.
